uart_rx_fifo: RTL

Parametrised UART receive channel for the SPART datapath: oversamples the serial `rxd` line, validates start/stop (and optionally parity) bits, and deposits completed characters in an internal receive FIFO read by the bus interface. It replaces the fixed 8-bit, single-rate receive path with configurable character width, oversampling ratio, and buffer depth, plus glitch rejection and sticky error reporting.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_buffer.sv | 52 +++++
 rtl/uart_rx_fifo.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the SPART UART receive path: receiver states and sticky error flags.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  typedef struct packed {
    logic frame;
    logic parity;
    logic overrun;
  } rx_err_t;

endpackage

// File: rtl/uart_rx_buffer.sv
// Circular receive FIFO, first-word-fall-through; a push into a full buffer only lands
// when a pop happens in the same cycle.
module uart_rx_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        push_ok, pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointers are exactly AW bits wide, so wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive channel: rxd synchroniser, oversampled bit FSM, sticky errors, receive FIFO.
// Define UART_RX_PARITY_EN to expect a parity bit after the data bits (PARITY_ODD selects odd).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_tick,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          rda,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID_TICK = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] BIT_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxd_s;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bad_q, par_bad_d;
  rx_err_t              err_q, err_set;
  logic                 push, buf_full, buf_empty;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_bad_q <= 1'b0;
      err_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
      err_q     <= (clr_err ? rx_err_t'('0) : err_q) | err_set;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    push      = 1'b0;
    err_set   = '0;
    if (baud_tick) begin
      case (state_q)
        IDLE: if (!rxd_s) begin
          state_d = START;
          tick_d  = '0;
        end
        // Half a bit in: a line that is high again was only a glitch.
        START: if (tick_q == MID_TICK) begin
          tick_d    = '0;
          bit_d     = '0;
          par_bad_d = 1'b0;
          state_d   = rxd_s ? IDLE : DATA;
        end else tick_d = tick_q + 1'b1;
        DATA: if (tick_q == BIT_TICK) begin
          tick_d  = '0;
          shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else bit_d = bit_q + 1'b1;
        end else tick_d = tick_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick_q == BIT_TICK) begin
          tick_d         = '0;
          par_bad_d      = rxd_s != (^shreg_q ^ (PARITY_ODD != 0));
          err_set.parity = par_bad_d;
          state_d        = STOP;
        end else tick_d = tick_q + 1'b1;
`endif
        STOP: if (tick_q == BIT_TICK) begin
          tick_d = '0;
          if (rxd_s) begin
            push    = !par_bad_q;
            state_d = IDLE;
          end else begin
            err_set.frame = 1'b1;
            state_d       = BREAK;
          end
        end else tick_d = tick_q + 1'b1;
        BREAK: if (rxd_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // A same-cycle read frees the slot, so only an unread full buffer overruns.
    err_set.overrun = push && buf_full && !rd_en;
  end

  uart_rx_buffer #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (rd_en),
    .wr_data (shreg_q),
    .rd_data (dout),
    .count   (count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  assign rda       = !buf_empty;
  assign frame_err = err_q.frame;
  assign overrun   = err_q.overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err = err_q.parity;
`else
  assign parity_err = 1'b0;
`endif

endmodule
